// File: rtl/exu_alu_wb_if.sv
// Decode-to-execute issue channel plus the execute-to-writeback return path.
// master = decode side, slave = execute stage.
interface exu_alu_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LEN     = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] rs1_val_i;
  logic [DATA_WIDTH-1:0] rs2_val_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic                  use_imm_i;
  logic                  use_rd_i;
  logic [RD_LEN-1:0]     rd_i;
  logic [3:0]            alu_op_i;
  logic                  invld_i;
  logic [RD_LEN-1:0]     wb_rd_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_en_o;
  logic                  busy_o;
  logic                  invld_err_o;

  modport master (
    output in_valid, rs1_val_i, rs2_val_i, imm_i, use_imm_i, use_rd_i,
           rd_i, alu_op_i, invld_i,
    input  in_ready, wb_rd_o, wb_dat_o, wb_en_o, busy_o, invld_err_o
  );

  modport slave (
    input  in_valid, rs1_val_i, rs2_val_i, imm_i, use_imm_i, use_rd_i,
           rd_i, alu_op_i, invld_i,
    output in_ready, wb_rd_o, wb_dat_o, wb_en_o, busy_o, invld_err_o
  );
endinterface

// File: rtl/exu_alu_wb.sv
// Execute stage: single-cycle ALU ops, iterative 1-bit/cycle shifter with
// issue stall, and sticky flagging of invalid instructions.
module exu_alu_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LEN     = 5,
  parameter int SHAMT_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  exu_alu_wb_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [SHAMT_W-1:0]    shamt;
  logic [SHAMT_W-1:0]    cnt_q;
  logic [RD_LEN-1:0]     rd_q;
  logic                  is_shift, we, accept, start_shift, last_shift;
  logic                  left_q, arith_q, we_q;

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy_o   = (state_q == SHIFT);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    op2         = bus.use_imm_i ? bus.imm_i : bus.rs2_val_i;
    shamt       = op2[SHAMT_W-1:0];
    is_shift    = (bus.alu_op_i[1:0] == 2'b01);
    we          = bus.use_rd_i && !bus.invld_i && (bus.rd_i != '0);
    accept      = bus.in_valid && (state_q == IDLE);
    start_shift = accept && !bus.invld_i && is_shift && (shamt != '0);
    last_shift  = (state_q == SHIFT) && (cnt_q == SHAMT_W'(1));
    shreg_next  = left_q ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                         : {arith_q & shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};

    alu_res = bus.rs1_val_i;
    case (bus.alu_op_i[2:0])
      3'b000:  alu_res = bus.alu_op_i[3] ? bus.rs1_val_i - op2 : bus.rs1_val_i + op2;
      3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.rs1_val_i) < $signed(op2)};
      3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.rs1_val_i < op2};
      3'b100:  alu_res = bus.rs1_val_i ^ op2;
      3'b110:  alu_res = bus.rs1_val_i | op2;
      3'b111:  alu_res = bus.rs1_val_i & op2;
      default: alu_res = bus.rs1_val_i;  // shift by zero returns rs1 unchanged
    endcase

    if (start_shift)     state_d = SHIFT;
    else if (last_shift) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_rd_o     <= '0;
      bus.wb_dat_o    <= '0;
      bus.wb_en_o     <= 1'b0;
      bus.invld_err_o <= 1'b0;
      shreg_q         <= '0;
      cnt_q           <= '0;
      rd_q            <= '0;
      left_q          <= 1'b0;
      arith_q         <= 1'b0;
      we_q            <= 1'b0;
    end else begin
      bus.wb_en_o <= 1'b0;  // strobe lasts exactly one cycle per write
      if (accept) begin
        if (bus.invld_i) begin
          bus.invld_err_o <= 1'b1;
        end else if (start_shift) begin
          shreg_q <= bus.rs1_val_i;
          cnt_q   <= shamt;
          left_q  <= ~bus.alu_op_i[2];
          arith_q <= bus.alu_op_i[3];
          rd_q    <= bus.rd_i;
          we_q    <= we;
        end else begin
          bus.wb_dat_o <= alu_res;
          bus.wb_rd_o  <= bus.rd_i;
          bus.wb_en_o  <= we;
        end
      end
      if (state_q == SHIFT) begin
        shreg_q <= shreg_next;
        cnt_q   <= cnt_q - SHAMT_W'(1);
        if (last_shift) begin
          bus.wb_dat_o <= shreg_next;
          bus.wb_rd_o  <= rd_q;
          bus.wb_en_o  <= we_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_wb.sv
// Self-checking bench for exu_alu_wb: directed scenarios followed by random
// instructions compared against an arithmetic reference model.
module tb_exu_alu_wb;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic err_model = 1'b0;

  exu_alu_wb_if bus ();

  exu_alu_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op[2:0] == 3'b001) || (op[2:0] == 3'b101);
  endfunction

  // Reference result computed directly from the opcode table.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    casez (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b?001: return a << sh;
      4'b?010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b?011: return (a < b) ? 32'd1 : 32'd0;
      4'b?100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b?110: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic use_rd,
                       input logic [4:0] rd, input logic invld);
    bus.in_valid  = 1'b1;
    bus.alu_op_i  = op;
    bus.rs1_val_i = a;
    bus.rs2_val_i = b;
    bus.imm_i     = imm;
    bus.use_imm_i = use_imm;
    bus.use_rd_i  = use_rd;
    bus.rd_i      = rd;
    bus.invld_i   = invld;
  endtask

  // Issue one instruction from IDLE and check stall length, result and strobe.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic use_imm,
                        input logic use_rd, input logic [4:0] rd, input logic invld);
    logic [31:0] op2, exp_dat;
    logic        exp_we;
    int          exp_n, busy_cnt;
    logic        stall_ok;
    op2     = use_imm ? imm : b;
    exp_dat = model(op, a, op2);
    exp_we  = use_rd && !invld && (rd != 5'd0);
    exp_n   = (!invld && is_shift_op(op)) ? int'(op2[4:0]) : 0;
    if (invld) err_model = 1'b1;

    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    drive(op, a, b, imm, use_imm, use_rd, rd, invld);
    @(negedge clk);
    bus.in_valid = 1'b0;
    busy_cnt = 0;
    stall_ok = 1'b1;
    while (bus.busy_o === 1'b1 && busy_cnt < 40) begin
      if (bus.in_ready !== 1'b0 || bus.wb_en_o !== 1'b0) stall_ok = 1'b0;
      @(negedge clk);
      busy_cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_n));
    if (exp_n > 0) check({tag, "_stall"}, 32'(stall_ok), 32'd1);
    check({tag, "_wb_en"}, 32'(bus.wb_en_o), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_wb_dat"}, bus.wb_dat_o, exp_dat);
      check({tag, "_wb_rd"}, 32'(bus.wb_rd_o), 32'(rd));
    end
    check({tag, "_err"}, 32'(bus.invld_err_o), 32'(err_model));
    @(negedge clk);
    check({tag, "_wb_en_drop"}, 32'(bus.wb_en_o), 32'd0);
  endtask

  initial begin
    logic        seen_wb;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, r_imm;

    rst = 1'b1;
    drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en_o), 32'd0);
    check("rst_wb_dat", bus.wb_dat_o, 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    check("rst_err", 32'(bus.invld_err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // add with wrap-around: 5 + (-3) = 2
    run_op("add", 4'b0000, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1, 5'd3, 1'b0);

    // back-to-back single-cycle ops
    drive(4'b1000, 32'd10, 32'd3, 32'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    @(negedge clk);
    check("b2b_sub_en", 32'(bus.wb_en_o), 32'd1);
    check("b2b_sub_dat", bus.wb_dat_o, 32'd7);
    check("b2b_sub_rd", 32'(bus.wb_rd_o), 32'd4);
    check("b2b_ready", 32'(bus.in_ready), 32'd1);
    drive(4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    check("b2b_sltu_en", 32'(bus.wb_en_o), 32'd1);
    check("b2b_sltu_dat", bus.wb_dat_o, 32'd1);
    check("b2b_sltu_rd", 32'(bus.wb_rd_o), 32'd5);
    drive(4'b0010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_slt_en", 32'(bus.wb_en_o), 32'd1);
    check("b2b_slt_dat", bus.wb_dat_o, 32'd0);
    check("b2b_slt_rd", 32'(bus.wb_rd_o), 32'd6);
    @(negedge clk);
    check("b2b_en_drop", 32'(bus.wb_en_o), 32'd0);

    // iterative shifts, zero shift amount, ignored upper op2 bits
    run_op("sra", 4'b1101, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    run_op("sll0", 4'b0001, 32'h0000_1234, 32'd0, 32'h0000_0020, 1'b1, 1'b1, 5'd8, 1'b0);
    run_op("sll_hi", 4'b1001, 32'h0000_1234, 32'hFFFF_FFE3, 32'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    run_op("srl31", 4'b0101, 32'h8000_0001, 32'd0, 32'd31, 1'b1, 1'b1, 5'd31, 1'b0);

    // suppressed writes
    run_op("x0", 4'b0000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    run_op("nord", 4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0, 5'd8, 1'b0);

    // invalid instruction sets a sticky flag that survives later valid ops
    run_op("invld", 4'b0000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      r_a = $urandom;
      r_b = $urandom;
      r_op = {$urandom_range(0, 1) == 1, 3'b100 | 3'($urandom_range(0, 3))};
      run_op("sticky", r_op, r_a, r_b, 32'd0, 1'b0, 1'b1, 5'($urandom_range(1, 31)), 1'b0);
    end

    // reset in the middle of a long shift aborts it
    check("mid_ready", 32'(bus.in_ready), 32'd1);
    drive(4'b0101, 32'hFFFF_0000, 32'd0, 32'd20, 1'b1, 1'b1, 5'd10, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_en_o !== 1'b0) seen_wb = 1'b1;
      @(negedge clk);
    end
    check("mid_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_model = 1'b0;
    check("mid_ready_after", 32'(bus.in_ready), 32'd1);
    check("mid_busy_after", 32'(bus.busy_o), 32'd0);
    check("mid_err_cleared", 32'(bus.invld_err_o), 32'd0);
    for (int i = 0; i < 25; i++) begin
      if (bus.wb_en_o !== 1'b0) seen_wb = 1'b1;
      @(negedge clk);
    end
    check("mid_no_wb", 32'(seen_wb), 32'd0);
    run_op("post_rst_add", 4'b0000, 32'd100, 32'd23, 32'd0, 1'b0, 1'b1, 5'd11, 1'b0);

    // random instructions against the reference model
    for (int i = 0; i < 120; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r_imm = ($urandom_range(0, 3) == 0) ? ~32'($urandom_range(0, 40)) : $urandom;
      run_op("rand", r_op, r_a, r_b, r_imm, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
             $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
